serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 116 +++++++++++
 tb/tb_serial_subtractor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: the FSM state encoding and
// the width helper used to size the bit counter.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Ceiling log2, never below 1, so the counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result++;
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = a - b - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: computes a - b - bin LSB first through one
// full-subtractor cell, with registered results and a one-cycle done pulse.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned      CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic fs_d;
  logic fs_bo;

  full_subtractor u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .bi (brw_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no
    // path through the case below can leave a signal unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          d_sh_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        d_sh_d = {fs_d, d_sh_q[WIDTH-1:1]};
        brw_d  = fs_bo;
        cnt_d  = cnt_q + CNT_W'(1);
        // Results are published only on the last bit, never mid-operation.
        if (cnt_q == LAST) begin
          diff_d  = d_sh_d;
          bout_d  = fs_bo;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all registers, including the shift and result registers, are reset,
    // so an aborted operation leaves no stale partial value behind.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed WIDTH=4 scenarios and a
// randomized WIDTH=8 run compared against plain-arithmetic subtraction.
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one WIDTH=4 operation from the current cycle (cycle 0). With ign set,
  // a second start carrying different operands is pulsed in cycle 2.
  task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bv_in,
                     input bit ign, input string tag);
    logic [4:0] expv;
    expv   = {1'b0, av} - {1'b0, bv} - {4'b0, bv_in};
    a4     = av;
    b4     = bv;
    bin4   = bv_in;
    start4 = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s busy c%0d", tag, cyc), 32'(busy4), 32'(cyc <= 4));
      check($sformatf("%s done c%0d", tag, cyc), 32'(done4), 32'(cyc == 5));
      if (cyc == 1) begin
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        bin4   = 1'($urandom);
      end
      if (ign && cyc == 2) begin
        a4     = 4'd0;
        b4     = 4'd5;
        start4 = 1'b1;
      end
      if (ign && cyc == 3) start4 = 1'b0;
    end
    check({tag, " diff"}, 32'(diff4), 32'(expv[3:0]));
    check({tag, " bout"}, 32'(bout4), 32'(expv[4]));
  endtask

  // Runs one WIDTH=8 operation and measures the start-to-done latency.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bv_in);
    logic [8:0] expv;
    int         lat;
    expv   = {1'b0, av} - {1'b0, bv} - {8'b0, bv_in};
    a8     = av;
    b8     = bv;
    bin8   = bv_in;
    start8 = 1'b1;
    lat    = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start8 = 1'b0;
      if (done8 === 1'b1) begin
        lat = cyc;
        break;
      end
    end
    check("w8 latency", 32'(lat), 32'd9);
    check("w8 diff", 32'(diff8), 32'(expv[7:0]));
    check("w8 bout", 32'(bout8), 32'(expv[8]));
  endtask

  initial begin
    bit seen_done;
    rst_n  = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    #12;
    check("reset busy", 32'(busy4), 32'd0);
    check("reset done", 32'(done4), 32'd0);
    check("reset diff", 32'(diff4), 32'd0);
    check("reset bout", 32'(bout4), 32'd0);
    check("reset busy8", 32'(busy8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    op4(4'd9, 4'd3, 1'b0, 1'b0, "basic");
    @(posedge clk);
    #1;
    check("basic done pulse width", 32'(done4), 32'd0);
    op4(4'd3, 4'd9, 1'b0, 1'b0, "negative");
    op4(4'd0, 4'd0, 1'b1, 1'b0, "zero minus bin");
    @(posedge clk);
    #1;
    op4(4'd15, 4'd1, 1'b0, 1'b1, "ignored start");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("ignored start no extra done", 32'(done4), 32'd0);
    end
    check("ignored start diff hold", 32'(diff4), 32'hE);

    op4(4'd8, 4'd8, 1'b0, 1'b0, "b2b first");
    op4(4'd12, 4'd5, 1'b1, 1'b0, "b2b second");

    // Reset in cycle 3 of an operation: outputs clear without a clock edge.
    a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1) start4 = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy4), 32'd0);
    check("midreset done", 32'(done4), 32'd0);
    check("midreset diff", 32'(diff4), 32'd0);
    check("midreset bout", 32'(bout4), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done4 !== 1'b0) seen_done = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done4 !== 1'b0 || busy4 !== 1'b0) seen_done = 1'b1;
    end
    check("midreset no done", 32'(seen_done), 32'd0);
    op4(4'd5, 4'd2, 1'b0, 1'b0, "after reset");

    // Boundary operands on the wide instance, then random traffic.
    op8(8'hFF, 8'hFF, 1'b1);
    op8(8'h00, 8'hFF, 1'b0);
    op8(8'hFF, 8'h00, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
